// File: rtl/cmm_operand_packer_if.sv
// Element-input and operand-vector-output bundle for cmm_operand_packer.
// The optional length/pad-error outputs exist only when CMM_PACKER_LEN_EN is defined.
interface cmm_operand_packer_if #(
   parameter int SIZE         = 16,
   parameter int WIDTH        = 64,
   parameter int NUM_OPERANDS = 4
);
   logic                                     flush_i;
   logic                                     elem_valid_i;
   logic                                     elem_ready_o;
   logic [NUM_OPERANDS-1:0][WIDTH-1:0]       elem_i;
   logic                                     elem_last_i;
   logic                                     out_valid_o;
   logic                                     out_ready_i;
   logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]  operands_o;
   logic                                     busy_o;
`ifdef CMM_PACKER_LEN_EN
   logic [$clog2(SIZE+1)-1:0]                vec_len_o;
   logic                                     pad_err_o;
`endif

   // Environment side: feeds elements, consumes operand vectors.
   modport master (
      output flush_i, elem_valid_i, elem_i, elem_last_i, out_ready_i,
`ifdef CMM_PACKER_LEN_EN
      input  vec_len_o, pad_err_o,
`endif
      input  elem_ready_o, out_valid_o, operands_o, busy_o
   );

   // Packer side.
   modport slave (
      input  flush_i, elem_valid_i, elem_i, elem_last_i, out_ready_i,
`ifdef CMM_PACKER_LEN_EN
      output vec_len_o, pad_err_o,
`endif
      output elem_ready_o, out_valid_o, operands_o, busy_o
   );
endinterface

// File: rtl/cmm_operand_packer.sv
// cmm_operand_packer: collects up to SIZE complex element pairs per vector into a
// ping-pong pair of banks and presents the completed bank as one wide operand bus.
// Slots beyond the vector length are forced to +0.0 on the output.
// Optional macro CMM_PACKER_LEN_EN adds vec_len_o and pad_err_o.
module cmm_operand_packer #(
   parameter int SIZE         = 16,
   parameter int WIDTH        = 64,
   parameter int NUM_OPERANDS = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   cmm_operand_packer_if.slave  bus
);
   localparam int CNT_W = $clog2(SIZE);
   localparam int LEN_W = $clog2(SIZE + 1);

   typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_t;
   typedef logic [SIZE-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] bank_data_t;

   bank_state_t       state_q [2];
   bank_state_t       state_d [2];
   logic [LEN_W-1:0]  len_q [2];
   logic [LEN_W-1:0]  len_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic              ready_en_q;
   bank_data_t        data_q [2];
   logic              in_fire;
   logic              out_fire;
   logic              close;

   // ready_en_q keeps elem_ready_o low during reset and up to the first edge after release.
   assign bus.elem_ready_o = ready_en_q && (state_q[wr_bank_q] != FULL);
   assign bus.out_valid_o  = (state_q[rd_bank_q] == FULL);
   assign bus.busy_o       = (state_q[0] != EMPTY) || (state_q[1] != EMPTY);
   assign in_fire          = bus.elem_valid_i && bus.elem_ready_o;
   assign out_fire         = bus.out_valid_o && bus.out_ready_i;
   assign close            = in_fire && (bus.elem_last_i || (fill_cnt_q == CNT_W'(SIZE - 1)));

   // Next-state for bank states, lengths and pointers; flush overrides beats and drains.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      fill_cnt_d = fill_cnt_q;
      if (bus.flush_i) begin
         state_d[0] = EMPTY;
         state_d[1] = EMPTY;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         fill_cnt_d = '0;
      end else begin
         // wr_bank and rd_bank differ whenever both banks are busy, so these never collide.
         if (out_fire) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
         end
         if (in_fire) begin
            if (close) begin
               state_d[wr_bank_q] = FULL;
               len_d[wr_bank_q]   = LEN_W'(fill_cnt_q) + LEN_W'(1);
               fill_cnt_d         = '0;
               wr_bank_d          = ~wr_bank_q;
            end else begin
               state_d[wr_bank_q] = FILLING;
               fill_cnt_d         = fill_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= '{EMPTY, EMPTY};
         len_q      <= '{'0, '0};
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         fill_cnt_q <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         fill_cnt_q <= fill_cnt_d;
         ready_en_q <= 1'b1;
      end
   end

   // Element storage; no reset needed because the output mask hides anything not in a FULL bank.
   always_ff @(posedge clk_i) begin
      if (in_fire && !bus.flush_i) begin
         data_q[wr_bank_q][fill_cnt_q] <= bus.elem_i;
      end
   end

   // Present the read bank, zeroing every slot at or beyond its length.
   always_comb begin
      bus.operands_o = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (bus.out_valid_o && (LEN_W'(i) < len_q[rd_bank_q])) begin
            for (int k = 0; k < NUM_OPERANDS; k++) begin
               bus.operands_o[i*NUM_OPERANDS + k] = data_q[rd_bank_q][i][k];
            end
         end
      end
   end

`ifdef CMM_PACKER_LEN_EN
   logic pad_err_q;

   // One-cycle pulse after a vector is closed early by elem_last_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pad_err_q <= 1'b0;
      end else begin
         pad_err_q <= !bus.flush_i && close && bus.elem_last_i &&
                      (fill_cnt_q != CNT_W'(SIZE - 1));
      end
   end

   assign bus.pad_err_o = pad_err_q;
   assign bus.vec_len_o = bus.out_valid_o ? len_q[rd_bank_q] : '0;
`endif
endmodule

// File: tb/tb_cmm_operand_packer.sv
// Self-checking bench for cmm_operand_packer against a queue-based vector model.
module tb_cmm_operand_packer;
   localparam int SIZE  = 16;
   localparam int WIDTH = 64;
   localparam int NOP   = 4;
   localparam int LEN_W = $clog2(SIZE + 1);

   typedef logic [SIZE*NOP-1:0][WIDTH-1:0] vec_t;
   typedef logic [NOP-1:0][WIDTH-1:0]      elem_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmm_operand_packer_if #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_OPERANDS(NOP)) bus ();

   cmm_operand_packer #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_OPERANDS(NOP)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Model: completed vectors waiting for the multiplier, plus the one being assembled.
   vec_t pend_vec[$];
   int   pend_len[$];
   vec_t cur_vec;
   int   cur_cnt;
   bit   rdy_en;
   bit   exp_pad;
   int   cyc;
   int   checks;
   int   errors;

   function automatic bit m_valid();
      return pend_vec.size() > 0;
   endfunction

   function automatic bit m_ready();
      return rdy_en && (pend_vec.size() < 2);
   endfunction

   function automatic bit m_busy();
      return (pend_vec.size() > 0) || (cur_cnt > 0);
   endfunction

   function automatic vec_t m_ops();
      vec_t v;
      v = '0;
      if (pend_vec.size() > 0) v = pend_vec[0];
      return v;
   endfunction

   function automatic int m_len();
      return (pend_len.size() > 0) ? pend_len[0] : 0;
   endfunction

   function automatic void m_reset();
      pend_vec.delete();
      pend_len.delete();
      cur_vec = '0;
      cur_cnt = 0;
      rdy_en  = 1'b0;
      exp_pad = 1'b0;
   endfunction

   function automatic int diff_idx(vec_t a, vec_t b);
      for (int i = 0; i < SIZE*NOP; i++) if (a[i] !== b[i]) return i;
      return 0;
   endfunction

   function automatic elem_t rand_elem();
      elem_t e;
      for (int k = 0; k < NOP; k++) e[k] = {$urandom(), $urandom()};
      return e;
   endfunction

   task automatic idle();
      bus.flush_i      = 1'b0;
      bus.elem_valid_i = 1'b0;
      bus.elem_last_i  = 1'b0;
      bus.elem_i       = '0;
      bus.out_ready_i  = 1'b0;
   endtask

   // Advance one clock, updating the model from the inputs presented; returns at the next negedge.
   task automatic step();
      bit    in_f, out_f;
      elem_t e;
      in_f  = bus.elem_valid_i && m_ready();
      out_f = m_valid() && bus.out_ready_i;
      e     = bus.elem_i;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         m_reset();
      end else begin
         exp_pad = 1'b0;
         if (bus.flush_i) begin
            pend_vec.delete();
            pend_len.delete();
            cur_vec = '0;
            cur_cnt = 0;
         end else begin
            if (out_f) begin
               void'(pend_vec.pop_front());
               void'(pend_len.pop_front());
            end
            if (in_f) begin
               for (int k = 0; k < NOP; k++) cur_vec[cur_cnt*NOP + k] = e[k];
               cur_cnt++;
               if (bus.elem_last_i || cur_cnt == SIZE) begin
                  exp_pad = (cur_cnt < SIZE);
                  pend_vec.push_back(cur_vec);
                  pend_len.push_back(cur_cnt);
                  cur_vec = '0;
                  cur_cnt = 0;
               end
            end
         end
         rdy_en = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      bus.elem_valid_i = 1'b0;
      bus.out_ready_i  = 1'b1;
      for (int c = 0; c < 8 && m_valid(); c++) step();
      bus.out_ready_i  = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      m_reset();
      #12;
      checks++; if (bus.elem_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.elem_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
      checks++; if (bus.operands_o !== '0) begin errors++; $display("FAIL rst_ops word %0d got %h exp 0", diff_idx(bus.operands_o, '0), bus.operands_o[diff_idx(bus.operands_o, '0)]); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (bus.elem_ready_o !== 1'b0) begin errors++; $display("FAIL rel_ready got %b exp 0", bus.elem_ready_o); end
      @(negedge clk);
      step();
      checks++; if (bus.elem_ready_o !== 1'b1) begin errors++; $display("FAIL post_ready got %b exp 1", bus.elem_ready_o); end
   endtask

   task automatic test_full_vectors();
      elem_t e;
      vec_t  ev;
      logic [WIDTH-1:0] w;
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         for (int k = 0; k < NOP; k++) e[k] = $realtobits(real'(i + 100*k));
         bus.elem_i = e; bus.elem_valid_i = 1'b1; bus.elem_last_i = 1'b0;
         checks++; if (bus.elem_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready beat %0d got %b exp 1", i, bus.elem_ready_o); end
         step();
         if (i < SIZE-1) begin
            checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL full_early_valid beat %0d got %b exp 0", i, bus.out_valid_o); end
         end
      end
      bus.elem_valid_i = 1'b0;
      ev = m_ops();
      w  = $realtobits(205.0);
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", bus.out_valid_o); end
      checks++; if (bus.operands_o[4*5+2] !== w) begin errors++; $display("FAIL full_slot22 got %h exp %h", bus.operands_o[4*5+2], w); end
      checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL full_ops word %0d got %h exp %h", diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
`ifdef CMM_PACKER_LEN_EN
      checks++; if (bus.pad_err_o !== 1'b0) begin errors++; $display("FAIL full_pad got %b exp 0", bus.pad_err_o); end
      checks++; if (bus.vec_len_o !== LEN_W'(SIZE)) begin errors++; $display("FAIL full_len got %0d exp %0d", bus.vec_len_o, SIZE); end
`endif
      step();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL full_pulse got %b exp 0", bus.out_valid_o); end
      bus.out_ready_i = 1'b0;
   endtask

   // Run twice so the second short vector lands in a bank still holding a full vector.
   task automatic test_short_vector();
      elem_t e;
      vec_t  ev;
      bit    nz;
      logic [WIDTH-1:0] w;
      for (int rep = 0; rep < 2; rep++) begin
         bus.out_ready_i = 1'b1;
         for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NOP; k++) e[k] = $realtobits(real'(i + 1));
            bus.elem_i = e; bus.elem_valid_i = 1'b1; bus.elem_last_i = (i == 2);
            step();
         end
         bus.elem_valid_i = 1'b0; bus.elem_last_i = 1'b0;
         ev = m_ops();
         nz = 1'b0;
         for (int j = 12; j < SIZE*NOP; j++) if (bus.operands_o[j] !== 64'h0) nz = 1'b1;
         w = $realtobits(3.0);
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL short_valid rep %0d got %b exp 1", rep, bus.out_valid_o); end
         checks++; if (nz) begin errors++; $display("FAIL short_pad_zero rep %0d got nonzero exp 0", rep); end
         checks++; if (bus.operands_o[8] !== w) begin errors++; $display("FAIL short_slot8 rep %0d got %h exp %h", rep, bus.operands_o[8], w); end
         checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL short_ops rep %0d word %0d got %h exp %h", rep, diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
`ifdef CMM_PACKER_LEN_EN
         checks++; if (bus.vec_len_o !== LEN_W'(3)) begin errors++; $display("FAIL short_len got %0d exp 3", bus.vec_len_o); end
         checks++; if (bus.pad_err_o !== 1'b1) begin errors++; $display("FAIL short_pad got %b exp 1", bus.pad_err_o); end
`endif
         step();
`ifdef CMM_PACKER_LEN_EN
         checks++; if (bus.pad_err_o !== 1'b0) begin errors++; $display("FAIL short_pad_once got %b exp 0", bus.pad_err_o); end
`endif
         checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL short_pulse got %b exp 0", bus.out_valid_o); end
      end
      bus.out_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      int   beats = 0;
      int   stall = 0;
      bit   done  = 1'b0;
      vec_t ev;
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         ev = m_ops();
         checks++; if (bus.elem_ready_o !== m_ready()) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", c, bus.elem_ready_o, m_ready()); end
         checks++; if (bus.out_valid_o !== m_valid()) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp %b", c, bus.out_valid_o, m_valid()); end
         checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL bp_ops cyc %0d word %0d got %h exp %h", c, diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
         if (beats == 32 && stall == 0) begin
            checks++; if (bus.elem_ready_o !== 1'b0) begin errors++; $display("FAIL bp_drop got %b exp 0", bus.elem_ready_o); end
         end
         if (beats == 32 && stall < 5) stall++;
         bus.out_ready_i  = (beats >= 32 && stall >= 5) || beats >= 40;
         bus.elem_valid_i = (beats < 40);
         bus.elem_last_i  = (beats == 39);
         bus.elem_i       = rand_elem();
         if (bus.elem_valid_i && m_ready()) beats++;
         step();
         if (beats == 40 && !m_valid() && cur_cnt == 0) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("FAIL bp_timeout beats %0d exp 40", beats); end
      idle();
   endtask

   task automatic test_back_to_back();
      int   beats = 0;
      int   hs[$];
      vec_t ev;
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 150 && hs.size() < 4; c++) begin
         if (bus.out_valid_o === 1'b1) begin
            ev = m_ops();
            hs.push_back(cyc);
            checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL b2b_ops vec %0d word %0d got %h exp %h", hs.size(), diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
         end
         checks++; if (bus.elem_ready_o !== m_ready()) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", c, bus.elem_ready_o, m_ready()); end
         bus.elem_valid_i = (beats < 4*SIZE);
         bus.elem_last_i  = 1'b0;
         bus.elem_i       = rand_elem();
         if (bus.elem_valid_i && m_ready()) beats++;
         step();
      end
      checks++; if (hs.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", hs.size()); end
      for (int j = 1; j < hs.size(); j++) begin
         checks++; if (hs[j] - hs[j-1] != SIZE) begin errors++; $display("FAIL b2b_spacing %0d got %0d exp %0d", j, hs[j] - hs[j-1], SIZE); end
      end
      idle();
   endtask

   task automatic test_flush();
      vec_t ev;
      bus.out_ready_i = 1'b0;
      for (int i = 0; i < SIZE + 6; i++) begin
         bus.elem_i = rand_elem(); bus.elem_valid_i = 1'b1; bus.elem_last_i = 1'b0;
         step();
      end
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL fl_pre_valid got %b exp 1", bus.out_valid_o); end
      bus.elem_i = rand_elem();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0; bus.elem_valid_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", bus.out_valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fl_busy got %b exp 0", bus.busy_o); end
      checks++; if (bus.elem_ready_o !== 1'b1) begin errors++; $display("FAIL fl_ready got %b exp 1", bus.elem_ready_o); end
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         bus.elem_i = rand_elem(); bus.elem_valid_i = 1'b1;
         step();
      end
      bus.elem_valid_i = 1'b0;
      ev = m_ops();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL fl_post_valid got %b exp 1", bus.out_valid_o); end
      checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL fl_post_ops word %0d got %h exp %h", diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
      drain();
      idle();
   endtask

   task automatic test_async_reset();
      vec_t ev;
      bus.out_ready_i = 1'b0;
      for (int i = 0; i < SIZE + 5; i++) begin
         bus.elem_i = rand_elem(); bus.elem_valid_i = 1'b1; bus.elem_last_i = 1'b0;
         step();
      end
      bus.elem_valid_i = 1'b0;
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got %b exp 1", bus.busy_o); end
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", bus.out_valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", bus.busy_o); end
      checks++; if (bus.elem_ready_o !== 1'b0) begin errors++; $display("FAIL ar_ready got %b exp 0", bus.elem_ready_o); end
      @(negedge clk);
      step();
      rst_n = 1'b1;
      step();
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         bus.elem_i = rand_elem(); bus.elem_valid_i = 1'b1;
         step();
      end
      bus.elem_valid_i = 1'b0;
      ev = m_ops();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL ar_post_valid got %b exp 1", bus.out_valid_o); end
      checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL ar_post_ops word %0d got %h exp %h", diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
      drain();
      idle();
   endtask

   task automatic test_random();
      vec_t ev;
      for (int c = 0; c < 600; c++) begin
         ev = m_ops();
         checks++; if (bus.elem_ready_o !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, bus.elem_ready_o, m_ready()); end
         checks++; if (bus.out_valid_o !== m_valid()) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bus.out_valid_o, m_valid()); end
         checks++; if (bus.busy_o !== m_busy()) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, bus.busy_o, m_busy()); end
         checks++; if (bus.operands_o !== ev) begin errors++; $display("FAIL rnd_ops cyc %0d word %0d got %h exp %h", c, diff_idx(bus.operands_o, ev), bus.operands_o[diff_idx(bus.operands_o, ev)], ev[diff_idx(bus.operands_o, ev)]); end
`ifdef CMM_PACKER_LEN_EN
         checks++; if (bus.vec_len_o !== LEN_W'(m_len())) begin errors++; $display("FAIL rnd_len cyc %0d got %0d exp %0d", c, bus.vec_len_o, m_len()); end
         checks++; if (bus.pad_err_o !== exp_pad) begin errors++; $display("FAIL rnd_pad cyc %0d got %b exp %b", c, bus.pad_err_o, exp_pad); end
`endif
         bus.elem_valid_i = ($urandom_range(9) < 7);
         bus.elem_last_i  = ($urandom_range(9) == 0);
         bus.out_ready_i  = ($urandom_range(9) < 5);
         bus.flush_i      = ($urandom_range(99) < 2);
         bus.elem_i       = rand_elem();
         step();
      end
      idle();
      bus.flush_i = 1'b1;
      step();
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      test_reset();
      test_full_vectors();
      test_short_vector();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
